copro_exec_result_queue: RTL

COPRO_EXEC_RESULT_QUEUE -- requirements
Module: copro_exec_result_queue

---
 rtl/copro_exec_result_queue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/copro_exec_result_queue.sv
// Coprocessor exec unit: single-cycle ALU ops plus a multi-cycle add,
// results retired in order through a small FIFO.
module copro_exec_result_queue #(
  parameter int XLEN         = 32,
  parameter int Depth        = 4,
  parameter int MultiLatency = 4,
  parameter int IdWidth      = 4,
  parameter int HartidWidth  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  input  logic [2:0]             opcode_i,
  input  logic [XLEN-1:0]        rs1_i,
  input  logic [XLEN-1:0]        rs2_i,
  input  logic [5:0]             imm_i,
  input  logic [4:0]             rd_i,
  input  logic [IdWidth-1:0]     id_i,
  input  logic [HartidWidth-1:0] hartid_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [XLEN-1:0]        result_data_o,
  output logic [4:0]             result_rd_o,
  output logic [IdWidth-1:0]     result_id_o,
  output logic [HartidWidth-1:0] result_hartid_o,
  output logic                   result_we_o
);

  localparam int AW   = $clog2(Depth);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(MultiLatency);

  localparam logic [2:0] OP_NOP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MULTI = 3'd3;
  localparam logic [2:0] OP_DBL   = 3'd4;
  localparam logic [2:0] OP_ADDI  = 3'd5;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;

  logic [XLEN-1:0]        r_m_data;
  logic [4:0]             r_m_rd;
  logic [IdWidth-1:0]     r_m_id;
  logic [HartidWidth-1:0] r_m_hart;

  logic [XLEN-1:0]        r_data [Depth];
  logic [4:0]             r_rd   [Depth];
  logic [IdWidth-1:0]     r_id   [Depth];
  logic [HartidWidth-1:0] r_hart [Depth];
  logic                   r_we   [Depth];

  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CNTW-1:0] r_count;

  logic                   w_accept, w_pop, w_push;
  logic                   w_multi_go, w_multi_push;
  logic                   w_imm_push, w_imm_we;
  logic [XLEN-1:0]        w_imm_data, w_sum;
  logic [XLEN-1:0]        w_p_data;
  logic [4:0]             w_p_rd;
  logic [IdWidth-1:0]     w_p_id;
  logic [HartidWidth-1:0] w_p_hart;
  logic                   w_p_we;

  assign op_ready_o = (r_state == S_IDLE) && (r_count < CNTW'(Depth));
  assign w_accept   = op_valid_i && op_ready_o;
  assign w_sum      = rs1_i + rs2_i;
  assign w_multi_go = w_accept && (opcode_i == OP_MULTI);

  // Single-cycle ops; illegal opcodes fall to default and never push.
  always_comb begin
    w_imm_push = 1'b0;
    w_imm_we   = 1'b0;
    w_imm_data = '0;
    case (opcode_i)
      OP_NOP: w_imm_push = w_accept;
      OP_ADD: begin
        w_imm_push = w_accept;
        w_imm_we   = 1'b1;
        w_imm_data = w_sum;
      end
      OP_DBL: begin
        w_imm_push = w_accept;
        w_imm_we   = 1'b1;
        w_imm_data = {rs1_i[XLEN-2:0], 1'b0};
      end
      OP_ADDI: begin
        w_imm_push = w_accept;
        w_imm_we   = 1'b1;
        w_imm_data = rs1_i + XLEN'(imm_i);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_multi_push = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_multi_go) begin
          w_state_n = S_BUSY;
          w_cnt_n   = CW'(MultiLatency - 1);
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_multi_push = 1'b1;
          w_state_n    = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Multi push and single-cycle push are exclusive: no accepts while busy.
  always_comb begin
    w_push   = w_imm_push || w_multi_push;
    w_p_data = w_imm_data;
    w_p_rd   = rd_i;
    w_p_id   = id_i;
    w_p_hart = hartid_i;
    w_p_we   = w_imm_we;
    if (w_multi_push) begin
      w_p_data = r_m_data;
      w_p_rd   = r_m_rd;
      w_p_id   = r_m_id;
      w_p_hart = r_m_hart;
      w_p_we   = 1'b1;
    end
  end

  assign result_valid_o = (r_count != '0);
  assign w_pop          = result_valid_o && result_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_multi_go) begin
      r_m_data <= w_sum;
      r_m_rd   <= rd_i;
      r_m_id   <= id_i;
      r_m_hart <= hartid_i;
    end
    if (w_push) begin
      r_data[r_wptr] <= w_p_data;
      r_rd[r_wptr]   <= w_p_rd;
      r_id[r_wptr]   <= w_p_id;
      r_hart[r_wptr] <= w_p_hart;
      r_we[r_wptr]   <= w_p_we;
    end
  end

  assign result_data_o   = result_valid_o ? r_data[r_rptr] : '0;
  assign result_rd_o     = result_valid_o ? r_rd[r_rptr]   : '0;
  assign result_id_o     = result_valid_o ? r_id[r_rptr]   : '0;
  assign result_hartid_o = result_valid_o ? r_hart[r_rptr] : '0;
  assign result_we_o     = result_valid_o && r_we[r_rptr];

endmodule
